// File: rtl/core_gbus_loader_pkg.sv
// ============================================================================
// core_gbus_loader_pkg : shared state encoding and beat-count helper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package core_gbus_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned beats(input int unsigned gw, input int unsigned iw);
    return gw / iw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gbus_word_packer.sv
// ============================================================================
// gbus_word_packer : gathers narrow beats LSB-first into one wide word
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module gbus_word_packer
  import core_gbus_loader_pkg::*;
#(
  parameter int GW = 128,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clear,
  input  logic          i_beat_vld,
  input  logic [IW-1:0] i_beat_data,
  output logic [GW-1:0] o_word,
  output logic          o_word_vld
);

  localparam int BEATS = beats(GW, IW);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_pack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat_vld) begin
      r_pack[r_cnt*IW +: IW] <= i_beat_data;
      r_cnt <= (r_cnt == c_last_beat) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // The final beat bypasses the register so the word is ready in its accept cycle.
  always_comb begin
    o_word = r_pack;
    o_word[(BEATS-1)*IW +: IW] = i_beat_data;
  end

  assign o_word_vld = i_beat_vld && (r_cnt == c_last_beat);

endmodule

`default_nettype wire

// File: rtl/core_gbus_loader.sv
// ============================================================================
// core_gbus_loader : packs a host beat stream into gbus words and writes them
//                    to consecutive gbus addresses for one command at a time
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module core_gbus_loader
  import core_gbus_loader_pkg::*;
#(
  parameter int MAC_MULT_NUM         = 16,
  parameter int IDATA_WIDTH          = 8,
  parameter int HEAD_CORE_NUM        = 16,
  parameter int CMEM_ADDR_WIDTH      = 10,
  parameter int GBUS_DATA_WIDTH      = MAC_MULT_NUM * IDATA_WIDTH,
  parameter int GBUS_ADDR_WIDTH      = 2 + $clog2(HEAD_CORE_NUM) + CMEM_ADDR_WIDTH,
  parameter int INTERFACE_DATA_WIDTH = 16,
  parameter int LEN_WIDTH            = 12
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cmd_vld,
  output logic                            cmd_rdy,
  input  logic [GBUS_ADDR_WIDTH-1:0]      cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]            cmd_len,
  input  logic                            abort,
  input  logic [INTERFACE_DATA_WIDTH-1:0] in_data,
  input  logic                            in_vld,
  output logic                            in_rdy,
  output logic [GBUS_ADDR_WIDTH-1:0]      out_gbus_addr,
  output logic                            out_gbus_wen,
  output logic [GBUS_DATA_WIDTH-1:0]      out_gbus_wdata,
  output logic                            busy,
  output logic                            done
);

  if ((GBUS_DATA_WIDTH % INTERFACE_DATA_WIDTH) != 0) begin : g_width_check
    $error("GBUS_DATA_WIDTH must be a multiple of INTERFACE_DATA_WIDTH");
  end

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [GBUS_ADDR_WIDTH-1:0]   r_next_addr;
  logic [LEN_WIDTH-1:0]         r_remaining;
  logic [GBUS_ADDR_WIDTH-1:0]   r_gbus_addr;
  logic                         r_gbus_wen;
  logic [GBUS_DATA_WIDTH-1:0]   r_gbus_wdata;
  logic                         w_clear;
  logic                         w_beat_acc;
  logic [GBUS_DATA_WIDTH-1:0]   w_word;
  logic                         w_word_vld;

  gbus_word_packer #(
    .GW (GBUS_DATA_WIDTH),
    .IW (INTERFACE_DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rstn        (rstn),
    .i_clear     (w_clear),
    .i_beat_vld  (w_beat_acc),
    .i_beat_data (in_data),
    .o_word      (w_word),
    .o_word_vld  (w_word_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    cmd_rdy     = (r_state == IDLE);
    in_rdy      = (r_state == FILL) && !abort;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE) && !abort;
    unique case (r_state)
      IDLE: if (cmd_vld) w_state_nxt = (cmd_len == '0) ? DONE : FILL;
      FILL: begin
        if (abort)                                              w_state_nxt = IDLE;
        else if (w_word_vld && (r_remaining == LEN_WIDTH'(1))) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_beat_acc = in_vld && in_rdy;
  // Any partial word is dropped whenever we leave FILL or a command is cancelled.
  assign w_clear    = (r_state != FILL) || abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_next_addr  <= '0;
      r_remaining  <= '0;
      r_gbus_addr  <= '0;
      r_gbus_wen   <= 1'b0;
      r_gbus_wdata <= '0;
    end else begin
      r_gbus_wen <= w_word_vld;
      if ((r_state == IDLE) && cmd_vld) begin
        r_next_addr <= cmd_base_addr;
        r_remaining <= cmd_len;
      end
      if (w_word_vld) begin
        r_gbus_addr  <= r_next_addr;
        r_gbus_wdata <= w_word;
        r_next_addr  <= r_next_addr + GBUS_ADDR_WIDTH'(1);
        r_remaining  <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  assign out_gbus_addr  = r_gbus_addr;
  assign out_gbus_wen   = r_gbus_wen;
  assign out_gbus_wdata = r_gbus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_core_gbus_loader.sv
// ============================================================================
// tb_core_gbus_loader : directed + randomized self-checking bench
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_gbus_loader;

  localparam int IW    = 16;
  localparam int GW    = 128;
  localparam int AW    = 16;
  localparam int LW    = 12;
  localparam int BEATS = GW / IW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [AW-1:0] out_gbus_addr;
  logic          out_gbus_wen;
  logic [GW-1:0] out_gbus_wdata;
  logic          busy;
  logic          done;

  core_gbus_loader dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_base_addr  (cmd_base_addr),
    .cmd_len        (cmd_len),
    .abort          (abort),
    .in_data        (in_data),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .out_gbus_addr  (out_gbus_addr),
    .out_gbus_wen   (out_gbus_wen),
    .out_gbus_wdata (out_gbus_wdata),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled on the falling edge.
  logic [AW-1:0] wr_addr_q[$];
  logic [GW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc_q[$];
  int            rdy_cnt = 0;

  always @(negedge clk) begin
    if (out_gbus_wen) begin
      wr_addr_q.push_back(out_gbus_addr);
      wr_data_q.push_back(out_gbus_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (in_rdy) rdy_cnt++;
  end

  int total = 0;
  int bad   = 0;

  // Reference: beats of the current command, in host order.
  logic [IW-1:0] beats_q[$];
  int            first_acc;
  int            hs_cyc;

  task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] model_word(input int k);
    logic [GW-1:0] w = '0;
    for (int j = 0; j < BEATS; j++) w[j*IW +: IW] = beats_q[k*BEATS + j];
    return w;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int k);
    return AW'((int'(base) + k) % (1 << AW));
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    rdy_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len);
    int t = 0;
    cmd_base_addr = base;
    cmd_len       = len;
    cmd_vld       = 1'b1;
    while (!cmd_rdy && t < 50) begin step(); t++; end
    if (!cmd_rdy) chk("tmo_cmd_rdy", GW'(cmd_rdy), GW'(1));
    step();
    hs_cyc  = cyc;
    cmd_vld = 1'b0;
  endtask

  task automatic feed(input int n, input bit seq, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [IW-1:0] d;
      int t = 0;
      d = seq ? IW'(beats_q.size() + 1) : IW'($urandom);
      beats_q.push_back(d);
      if (gaps) begin
        int idle = $urandom_range(2, 0);
        in_vld = 1'b0;
        repeat (idle) step();
      end
      in_data = d;
      in_vld  = 1'b1;
      while (!in_rdy && t < 50) begin step(); t++; end
      if (!in_rdy) chk("tmo_in_rdy", GW'(in_rdy), GW'(1));
      step();
      if (beats_q.size() == 1) first_acc = cyc;
    end
    in_vld = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] base, input int n);
    chk({tag, "_nwr"}, GW'(wr_addr_q.size()), GW'(n));
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      chk({tag, "_addr"}, GW'(wr_addr_q[k]), GW'(model_addr(base, k)));
      chk({tag, "_data"}, wr_data_q[k], model_word(k));
    end
  endtask

  initial begin
    logic [AW-1:0] base;

    // Reset values
    repeat (3) step();
    chk("rst_wen",   GW'(out_gbus_wen), GW'(0));
    chk("rst_addr",  GW'(out_gbus_addr), GW'(0));
    chk("rst_wdata", out_gbus_wdata, GW'(0));
    chk("rst_done",  GW'(done), GW'(0));
    chk("rst_busy",  GW'(busy), GW'(0));
    chk("rst_inrdy", GW'(in_rdy), GW'(0));
    chk("rst_cmdrdy", GW'(cmd_rdy), GW'(1));
    rstn = 1'b1;
    repeat (2) step();

    // Back-to-back beats 1..16, two words at 0x010
    clear_mon(); beats_q.delete();
    send_cmd(16'h0010, 12'd2);
    chk("t1_busy", GW'(busy), GW'(1));
    feed(16, 1'b1, 1'b0);
    repeat (3) step();
    check_writes("t1", 16'h0010, 2);
    if (wr_cyc_q.size() == 2) begin
      chk("t1_cyc0", GW'(wr_cyc_q[0]), GW'(first_acc + BEATS - 1));
      chk("t1_cyc1", GW'(wr_cyc_q[1]), GW'(first_acc + 2*BEATS - 1));
    end
    chk("t1_ndone", GW'(done_cyc_q.size()), GW'(1));
    if (done_cyc_q.size() == 1 && wr_cyc_q.size() == 2)
      chk("t1_done_cyc", GW'(done_cyc_q[0]), GW'(wr_cyc_q[1]));
    chk("t1_idle", GW'(cmd_rdy), GW'(1));

    // Zero-length command
    clear_mon(); beats_q.delete();
    send_cmd(AW'($urandom), 12'd0);
    repeat (3) step();
    chk("t2_nwr", GW'(wr_addr_q.size()), GW'(0));
    chk("t2_ndone", GW'(done_cyc_q.size()), GW'(1));
    if (done_cyc_q.size() == 1) chk("t2_done_cyc", GW'(done_cyc_q[0]), GW'(hs_cyc));
    chk("t2_inrdy", GW'(rdy_cnt), GW'(0));

    // Random data with gaps, three words
    clear_mon(); beats_q.delete();
    base = AW'($urandom);
    send_cmd(base, 12'd3);
    feed(3*BEATS, 1'b0, 1'b1);
    repeat (3) step();
    check_writes("t3", base, 3);
    chk("t3_ndone", GW'(done_cyc_q.size()), GW'(1));

    // Address wrap
    clear_mon(); beats_q.delete();
    send_cmd(16'hFFFF, 12'd2);
    feed(2*BEATS, 1'b0, 1'b0);
    repeat (3) step();
    check_writes("t4", 16'hFFFF, 2);

    // Abort after five beats of word 2, then a fresh command
    clear_mon(); beats_q.delete();
    base = AW'($urandom);
    send_cmd(base, 12'd3);
    feed(BEATS + 5, 1'b0, 1'b0);
    in_data = IW'($urandom);
    in_vld  = 1'b1;
    abort   = 1'b1;
    #1;
    chk("t5_inrdy_abort", GW'(in_rdy), GW'(0));
    @(posedge clk); #1;
    abort  = 1'b0;
    in_vld = 1'b0;
    chk("t5_cmdrdy", GW'(cmd_rdy), GW'(1));
    chk("t5_busy", GW'(busy), GW'(0));
    repeat (4) step();
    check_writes("t5", base, 1);
    chk("t5_ndone", GW'(done_cyc_q.size()), GW'(0));
    clear_mon(); beats_q.delete();
    base = AW'($urandom);
    send_cmd(base, 12'd1);
    feed(BEATS, 1'b0, 1'b0);
    repeat (3) step();
    check_writes("t5b", base, 1);
    chk("t5b_ndone", GW'(done_cyc_q.size()), GW'(1));

    // Reset mid-word
    clear_mon(); beats_q.delete();
    send_cmd(AW'($urandom), 12'd2);
    feed(BEATS + 3, 1'b0, 1'b0);
    in_data = IW'($urandom);
    in_vld  = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("t6_wen",    GW'(out_gbus_wen), GW'(0));
    chk("t6_addr",   GW'(out_gbus_addr), GW'(0));
    chk("t6_wdata",  out_gbus_wdata, GW'(0));
    chk("t6_busy",   GW'(busy), GW'(0));
    chk("t6_inrdy",  GW'(in_rdy), GW'(0));
    chk("t6_cmdrdy", GW'(cmd_rdy), GW'(1));
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    clear_mon();
    repeat (20) step();
    in_vld = 1'b0;
    chk("t6_nwr", GW'(wr_addr_q.size()), GW'(0));
    chk("t6_ndone", GW'(done_cyc_q.size()), GW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
